// File: rtl/qdiv_seq_pkg.sv
// Shared definitions for the sequential sign-magnitude fixed-point divider:
// default word format and the controller state encoding.
package qdiv_seq_pkg;

    localparam int QDIV_N = 16;
    localparam int QDIV_Q = QDIV_N - 1;

    typedef enum logic [1:0] {
        QDIV_IDLE = 2'd0,
        QDIV_RUN  = 2'd1,
        QDIV_DONE = 2'd2
    } qdiv_state_e;

endpackage

// File: rtl/qdiv_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor magnitude if it fits, and report the quotient bit.
module qdiv_step #(
    parameter int N = 16
) (
    input  logic [N-1:0] rem_i,
    input  logic         bit_i,
    input  logic [N-2:0] div_i,
    output logic [N-1:0] rem_o,
    output logic         q_o
);

    logic [N:0] remShift;
    logic [N:0] divExt;

    // The remainder is always below the divisor, so the shifted value fits in N bits;
    // the extra bit only keeps the compare width-clean.
    always_comb begin
        remShift = {rem_i, bit_i};
        divExt   = {2'b00, div_i};
        q_o      = (remShift >= divExt);
        rem_o    = q_o ? N'(remShift - divExt) : N'(remShift);
    end

endmodule

// File: rtl/qdiv_seq.sv
// Sequential sign-magnitude Q-format divider (result = a / b), one quotient bit
// per clock, with a start/busy/done handshake and saturation / divide-by-zero flags.
module qdiv_seq
    import qdiv_seq_pkg::*;
#(
    parameter int N = QDIV_N,
    parameter int Q = QDIV_Q
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         ovr,
    output logic         dz
);

    localparam int ITER = N - 1 + Q;
    localparam int CW   = $clog2(ITER);

    qdiv_state_e     state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sgn_q, sgn_d;
    logic [ITER-1:0] dvd_q, dvd_d;
    logic [N-1:0]    rem_q, rem_d;
    logic [ITER-1:0] quo_q, quo_d;
    logic [N-2:0]    bmag_q, bmag_d;
    logic [N-1:0]    result_q, result_d;
    logic            ovr_q, ovr_d;
    logic            dz_q, dz_d;

    logic [N-1:0]    remNext;
    logic            qBit;
    logic [ITER-1:0] quoNext;
    logic [N-2:0]    magNext;
    logic            ovrNext;

    qdiv_step #(.N(N)) u_step (
        .rem_i (rem_q),
        .bit_i (dvd_q[ITER-1]),
        .div_i (bmag_q),
        .rem_o (remNext),
        .q_o   (qBit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= QDIV_IDLE;
            cnt_q    <= '0;
            sgn_q    <= 1'b0;
            dvd_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            bmag_q   <= '0;
            result_q <= '0;
            ovr_q    <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sgn_q    <= sgn_d;
            dvd_q    <= dvd_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            bmag_q   <= bmag_d;
            result_q <= result_d;
            ovr_q    <= ovr_d;
            dz_q     <= dz_d;
        end
    end

    // Any quotient bit above the magnitude field means the result cannot be represented.
    always_comb begin
        quoNext = {quo_q[ITER-2:0], qBit};
        ovrNext = |quoNext[ITER-1:N-1];
        magNext = ovrNext ? {(N-1){1'b1}} : quoNext[N-2:0];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sgn_d    = sgn_q;
        dvd_d    = dvd_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        bmag_d   = bmag_q;
        result_d = result_q;
        ovr_d    = ovr_q;
        dz_d     = dz_q;

        unique case (state_q)
            QDIV_IDLE, QDIV_DONE: begin
                state_d = QDIV_IDLE;
                if (start) begin
                    sgn_d  = a[N-1] ^ b[N-1];
                    dvd_d  = {a[N-2:0], {Q{1'b0}}};
                    rem_d  = '0;
                    quo_d  = '0;
                    bmag_d = b[N-2:0];
                    cnt_d  = CW'(ITER - 1);
                    ovr_d  = 1'b0;
                    dz_d   = 1'b0;
                    // A zero divisor skips the iterations and reports a saturated quotient.
                    if (b[N-2:0] == '0) begin
                        state_d  = QDIV_DONE;
                        dz_d     = 1'b1;
                        result_d = {a[N-1] ^ b[N-1], {(N-1){1'b1}}};
                    end else begin
                        state_d = QDIV_RUN;
                    end
                end
            end
            QDIV_RUN: begin
                rem_d = remNext;
                quo_d = quoNext;
                dvd_d = {dvd_q[ITER-2:0], 1'b0};
                if (cnt_q == '0) begin
                    state_d  = QDIV_DONE;
                    ovr_d    = ovrNext;
                    result_d = {(magNext != '0) & sgn_q, magNext};
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = QDIV_IDLE;
        endcase
    end

    assign busy   = (state_q == QDIV_RUN);
    assign done   = (state_q == QDIV_DONE);
    assign result = result_q;
    assign ovr    = ovr_q;
    assign dz     = dz_q;

endmodule

// File: tb/tb_qdiv_seq.sv
// Self-checking bench for qdiv_seq (N=16, Q=15): directed vectors, divide by zero,
// randomized divides against an arithmetic reference, mid-run reset and handshake cases.
module tb_qdiv_seq;

    localparam int N        = 16;
    localparam int LAT_NORM = 31;
    localparam int LAT_DZ   = 1;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         ovr;
    logic         dz;

    int total = 0;
    int bad   = 0;

    qdiv_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .ovr    (ovr),
        .dz     (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: truncated (|a| * 2^15) / |b|, saturated to 15 bits, no negative zero.
    function automatic void ref_div(input logic [15:0] av, input logic [15:0] bv,
                                    output logic [15:0] r, output logic o, output logic z);
        longint unsigned am, bm, q;
        logic s;
        am = longint'(av[14:0]);
        bm = longint'(bv[14:0]);
        s  = av[15] ^ bv[15];
        o  = 1'b0;
        z  = 1'b0;
        if (bm == 0) begin
            z = 1'b1;
            q = 32767;
        end else begin
            q = (am << 15) / bm;
            if (q > 32767) begin
                q = 32767;
                o = 1'b1;
            end
        end
        r = (q == 0) ? 16'h0000 : {s, q[14:0]};
    endfunction

    // Present a request so that the next rising edge accepts it; returns one step after that edge.
    task automatic start_div(input logic [15:0] av, input logic [15:0] bv);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts cycles after the accept edge until done; -1 if it never arrives.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)     begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (result !== 16'h0)  begin bad++; $display("FAIL reset_result got=%h exp=0000", result); end
        total++; if (ovr !== 1'b0)      begin bad++; $display("FAIL reset_ovr got=%b exp=0", ovr); end
        total++; if (dz !== 1'b0)       begin bad++; $display("FAIL reset_dz got=%b exp=0", dz); end
        rst = 1'b0;
        idle_cycle();
    endtask

    task automatic test_directed();
        logic [15:0] va[5] = '{16'h4000, 16'h2000, 16'h6000, 16'h8000, 16'h0001};
        logic [15:0] vb[5] = '{16'h6000, 16'hC000, 16'h4000, 16'h4000, 16'h7FFF};
        logic [15:0] vr[5] = '{16'h5555, 16'hC000, 16'h7FFF, 16'h0000, 16'h0001};
        logic        vo[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int lat;
        for (int i = 0; i < 5; i++) begin
            start_div(va[i], vb[i]);
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL dir%0d_busy got=%b exp=1", i, busy); end
            wait_done(lat);
            total++; if (lat != LAT_NORM)   begin bad++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, LAT_NORM); end
            total++; if (result !== vr[i])  begin bad++; $display("FAIL dir%0d_result got=%h exp=%h", i, result, vr[i]); end
            total++; if (ovr !== vo[i])     begin bad++; $display("FAIL dir%0d_ovr got=%b exp=%b", i, ovr, vo[i]); end
            total++; if (dz !== 1'b0)       begin bad++; $display("FAIL dir%0d_dz got=%b exp=0", i, dz); end
            idle_cycle();
            total++; if (done !== 1'b0)     begin bad++; $display("FAIL dir%0d_done_pulse got=%b exp=0", i, done); end
            total++; if (result !== vr[i])  begin bad++; $display("FAIL dir%0d_held got=%h exp=%h", i, result, vr[i]); end
        end
    endtask

    task automatic test_div_zero();
        logic [15:0] va[2] = '{16'h2000, 16'hA000};
        logic [15:0] vb[2] = '{16'h8000, 16'h0000};
        int lat;
        for (int i = 0; i < 2; i++) begin
            start_div(va[i], vb[i]);
            wait_done(lat);
            total++; if (lat != LAT_DZ)       begin bad++; $display("FAIL dz%0d_latency got=%0d exp=%0d", i, lat, LAT_DZ); end
            total++; if (result !== 16'hFFFF) begin bad++; $display("FAIL dz%0d_result got=%h exp=ffff", i, result); end
            total++; if (dz !== 1'b1)         begin bad++; $display("FAIL dz%0d_flag got=%b exp=1", i, dz); end
            total++; if (ovr !== 1'b0)        begin bad++; $display("FAIL dz%0d_ovr got=%b exp=0", i, ovr); end
            idle_cycle();
        end
    endtask

    task automatic test_random();
        logic [15:0] av, bv, er;
        logic eo, ez;
        int lat;
        for (int i = 0; i < 40; i++) begin
            av = 16'($urandom);
            case ($urandom_range(0, 9))
                0:       bv = {1'($urandom), 15'h0000};
                1, 2:    bv = {1'($urandom), 15'($urandom_range(1, 255))};
                default: bv = 16'($urandom);
            endcase
            ref_div(av, bv, er, eo, ez);
            start_div(av, bv);
            wait_done(lat);
            total++; if (lat != (ez ? LAT_DZ : LAT_NORM)) begin bad++; $display("FAIL rnd%0d_latency a=%h b=%h got=%0d", i, av, bv, lat); end
            total++; if (result !== er) begin bad++; $display("FAIL rnd%0d_result a=%h b=%h got=%h exp=%h", i, av, bv, result, er); end
            total++; if (ovr !== eo)    begin bad++; $display("FAIL rnd%0d_ovr a=%h b=%h got=%b exp=%b", i, av, bv, ovr, eo); end
            total++; if (dz !== ez)     begin bad++; $display("FAIL rnd%0d_dz a=%h b=%h got=%b exp=%b", i, av, bv, dz, ez); end
            idle_cycle();
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        start_div(16'h4000, 16'h6000);
        for (int c = 1; c < 10; c++) begin
            total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_early_done cycle=%0d got=%b exp=0", c, done); end
            idle_cycle();
        end
        rst = 1'b1;
        idle_cycle();
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL midrst_done got=%b exp=0", done); end
        total++; if (result !== 16'h0) begin bad++; $display("FAIL midrst_result got=%h exp=0000", result); end
        total++; if (ovr !== 1'b0)     begin bad++; $display("FAIL midrst_ovr got=%b exp=0", ovr); end
        total++; if (dz !== 1'b0)      begin bad++; $display("FAIL midrst_dz got=%b exp=0", dz); end
        rst = 1'b0;
        start_div(16'h2000, 16'hC000);
        wait_done(lat);
        total++; if (lat != LAT_NORM)     begin bad++; $display("FAIL postrst_latency got=%0d exp=%0d", lat, LAT_NORM); end
        total++; if (result !== 16'hC000) begin bad++; $display("FAIL postrst_result got=%h exp=c000", result); end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        logic [15:0] va[4] = '{16'h4000, 16'h6000, 16'h1234, 16'hC000};
        logic [15:0] vb[4] = '{16'h6000, 16'h4000, 16'h0000, 16'h5000};
        logic [15:0] er;
        logic eo, ez;
        int lat;
        start_div(va[0], vb[0]);
        wait_done(lat);
        for (int i = 0; i < 4; i++) begin
            ref_div(va[i], vb[i], er, eo, ez);
            total++; if (lat != (ez ? LAT_DZ : LAT_NORM)) begin bad++; $display("FAIL b2b%0d_latency got=%0d", i, lat); end
            total++; if (result !== er) begin bad++; $display("FAIL b2b%0d_result got=%h exp=%h", i, result, er); end
            total++; if (ovr !== eo)    begin bad++; $display("FAIL b2b%0d_ovr got=%b exp=%b", i, ovr, eo); end
            total++; if (dz !== ez)     begin bad++; $display("FAIL b2b%0d_dz got=%b exp=%b", i, dz, ez); end
            if (i < 3) begin
                start_div(va[i+1], vb[i+1]);
                wait_done(lat);
            end
        end
        idle_cycle();
    endtask

    task automatic test_start_during_run();
        int lat;
        start_div(16'h2000, 16'h6000);
        repeat (4) idle_cycle();
        start = 1'b1;
        a     = 16'h7FFF;
        b     = 16'h0000;
        repeat (3) begin
            idle_cycle();
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL run_ignore_busy got=%b exp=1", busy); end
        end
        start = 1'b0;
        wait_done(lat);
        total++; if (lat != LAT_NORM - 7) begin bad++; $display("FAIL run_ignore_latency got=%0d exp=%0d", lat, LAT_NORM - 7); end
        total++; if (result !== 16'h2AAA) begin bad++; $display("FAIL run_ignore_result got=%h exp=2aaa", result); end
        total++; if (dz !== 1'b0)         begin bad++; $display("FAIL run_ignore_dz got=%b exp=0", dz); end
        idle_cycle();
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        test_reset();
        test_directed();
        test_div_zero();
        test_random();
        test_reset_mid_run();
        test_back_to_back();
        test_start_during_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
